// File: rtl/ifu_fetch_stage.sv
// ifu_fetch_stage: instruction fetch stage in front of decode.
//   Generates the PC, reads a 1-cycle-latency synchronous instruction ROM,
//   buffers returned words in a 2-entry FIFO and hands them to decode with a
//   valid/ready handshake. Jumps from execute flush everything in flight.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rom_req_o/addr_o    - ROM read request and byte address (addr = PC)
//   rom_data_i          - ROM word, valid the cycle after a request
//   jump_en_i/addr_i    - redirect; target bits [1:0] are forced to 0
//   inst_valid_o/inst_o/inst_addr_o/inst_ready_i - decode handshake
// Optional: define IFU_PERF_CNT_EN to add fetch_cnt_o (handshakes, wraps)
//   and flush_cnt_o (jump cycles, saturates).
module ifu_fetch_stage #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [31:0]        NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ready_i
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [15:0]       flush_cnt_o
`endif
);

  logic [ADDR_W-1:0]            pc_q;
  logic [ADDR_W-1:0]            req_addr_q;
  logic                         inflight_q;
  logic [1:0]                   cnt_q;
  logic                         wr_ptr_q, rd_ptr_q;
  logic [1:0][31:0]             inst_mem_q;
  logic [1:0][ADDR_W-1:0]       addr_mem_q;

  logic                         pop, push;
  logic [2:0]                   occ;

  assign pop  = (cnt_q != 2'd0) && inst_ready_i;
  // A response landing in the jump cycle belongs to the old stream.
  assign push = inflight_q && !jump_en_i;
  // Slots already claimed: buffered words plus the one returning now.
  assign occ  = {1'b0, cnt_q} + {2'b00, inflight_q};

  // occ - pop < 2, rearranged to avoid unsigned underflow.
  assign rom_req_o  = !rst && !jump_en_i && (occ < (3'd2 + {2'b00, pop}));
  assign rom_addr_o = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else if (jump_en_i) begin
      pc_q       <= {jump_addr_i[ADDR_W-1:2], 2'b00};
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      inflight_q <= rom_req_o;
      if (rom_req_o) begin
        pc_q       <= pc_q + ADDR_W'(4);
        req_addr_q <= pc_q;
      end
      if (push) begin
        inst_mem_q[wr_ptr_q] <= rom_data_i;
        addr_mem_q[wr_ptr_q] <= req_addr_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign inst_valid_o = (cnt_q != 2'd0);
  assign inst_o       = inst_valid_o ? inst_mem_q[rd_ptr_q] : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? addr_mem_q[rd_ptr_q] : '0;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pop) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (jump_en_i && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Bench for ifu_fetch_stage. The driver owns redirects and refills the
// expected instruction stream after each one; the negedge monitor compares
// every handshake against it and checks request/latency/stall rules using
// abstract counts of words requested and consumed since the last redirect.
module tb_ifu_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i = 1'b1;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [15:0] flush_cnt_o;
`endif

  ifu_fetch_stage #(.ADDR_W(32), .RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .inst_ready_i(inst_ready_i)
`ifdef IFU_PERF_CNT_EN
    , .fetch_cnt_o(fetch_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // ROM contents: word = address ^ salt; salt only changes while rst is held.
  logic [31:0] salt = '0;
  always @(posedge clk) if (rom_req_o) rom_data_i <= rom_addr_o ^ salt;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  int          since = 0;
  int          issued = 0, popped = 0;
  logic [31:0] req_next = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_inst, prev_addr;
  logic        pop, exp_req;
  logic [31:0] e;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] m_fetch = '0;
  logic [15:0] m_flush = '0;
`endif

  always @(negedge clk) begin
    pop = inst_valid_o && inst_ready_i;
`ifdef IFU_PERF_CNT_EN
    if (since > 0 || !rst) begin
      chk("fetch_cnt", fetch_cnt_o, m_fetch);
      chk("flush_cnt", {16'h0, flush_cnt_o}, {16'h0, m_flush});
    end
`endif
    if (rst) begin
      chk("req_in_rst", {31'h0, rom_req_o}, 32'h0);
      since = 0; issued = 0; popped = 0; req_next = RESET_PC; prev_stall = 1'b0;
`ifdef IFU_PERF_CNT_EN
      m_fetch = '0; m_flush = '0;
`endif
    end else begin
      if (since < 1000) since++;
      // A word requested in redirect-relative cycle 1 is visible in cycle 3.
      chk("valid", {31'h0, inst_valid_o}, {31'h0, since >= 3});
      if (!inst_valid_o) begin
        chk("nop_inst", inst_o, NOP);
        chk("nop_addr", inst_addr_o, 32'h0);
      end
      if (prev_stall) begin
        chk("stall_inst", inst_o, prev_inst);
        chk("stall_addr", inst_addr_o, prev_addr);
      end
      exp_req = !jump_en_i && ((issued - popped - int'(pop)) < 2);
      chk("rom_req", {31'h0, rom_req_o}, {31'h0, exp_req});
      if (rom_req_o && !jump_en_i) begin
        chk("rom_addr", rom_addr_o, req_next);
        req_next += 32'd4;
        issued++;
      end
      if (pop) begin
        popped++;
        if (exp_q.size() == 0) begin
          chk("stream_underflow", inst_addr_o, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("inst_addr", inst_addr_o, e);
          chk("inst_data", inst_o, e ^ salt);
        end
      end
      prev_stall = inst_valid_o && !inst_ready_i && !jump_en_i;
      prev_inst  = inst_o;
      prev_addr  = inst_addr_o;
`ifdef IFU_PERF_CNT_EN
      if (pop) m_fetch += 32'd1;
      if (jump_en_i && m_flush != 16'hFFFF) m_flush += 16'd1;
`endif
      if (jump_en_i) begin
        since = 0; issued = 0; popped = 0;
        req_next = {jump_addr_i[31:2], 2'b00};
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Expected delivery order after a redirect: target, target+4, ...
  task automatic fill(input logic [31:0] target);
    logic [31:0] a;
    a = {target[31:2], 2'b00};
    exp_q.delete();
    for (int i = 0; i < 1024; i++) begin
      exp_q.push_back(a);
      a += 32'd4;
    end
  endtask

  task automatic do_rst(input int n, input logic [31:0] new_salt);
    rst = 1'b1; jump_en_i = 1'b0;
    salt = new_salt;
    repeat (n) cyc();
    rst = 1'b0;
    fill(RESET_PC);
  endtask

  task automatic do_jump(input logic [31:0] a);
    jump_en_i = 1'b1; jump_addr_i = a;
    cyc();
    jump_en_i = 1'b0;
    fill(a);
  endtask

  logic [31:0] ra;
  int r;

  initial begin
    // Directed: reset then free-running fetch, ROM word == address.
    inst_ready_i = 1'b1;
    do_rst(2, 32'h0);
    repeat (8) cyc();

    // Stall at the first valid for 5 cycles, then drain.
    do_rst(1, 32'h0);
    cyc(); cyc();
    inst_ready_i = 1'b0;
    repeat (5) cyc();
    chk("stall_full_noreq", {31'h0, rom_req_o}, 32'h0);
    chk("stall_head", inst_addr_o, 32'h0);
    inst_ready_i = 1'b1;
    repeat (6) cyc();

    // Jump to 0x103 with a full FIFO followed by an in-flight response.
    inst_ready_i = 1'b0;
    repeat (4) cyc();
    inst_ready_i = 1'b1;
    cyc();
    inst_ready_i = 1'b0;
    do_jump(32'h0000_0103);
    chk("jump_rom_addr", rom_addr_o, 32'h100);
    inst_ready_i = 1'b1;
    repeat (6) cyc();

    // Back-to-back jumps: last target wins.
    jump_en_i = 1'b1; jump_addr_i = 32'h40;
    cyc();
    do_jump(32'h80);
    repeat (8) cyc();

    // Reset mid-stream with the FIFO full.
    inst_ready_i = 1'b0;
    repeat (4) cyc();
    do_rst(1, 32'h0);
    chk("rst_inst_nop", inst_o, NOP);
    inst_ready_i = 1'b1;
    repeat (6) cyc();

    // Randomised traffic with random ROM contents.
    do_rst(2, $urandom);
    for (int c = 0; c < 3000; c++) begin
      inst_ready_i = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 199);
      if (r < 6) begin
        ra = (r == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        if (r == 1) begin
          jump_en_i = 1'b1; jump_addr_i = $urandom;
          cyc();
        end
        do_jump(ra);
      end else if (r == 6) begin
        do_rst($urandom_range(1, 2), $urandom);
      end else begin
        cyc();
      end
    end
    inst_ready_i = 1'b1;
    repeat (5) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
